// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared constants for the pipelined MIPS core
//
// Holds the control-bundle layout used by the ID/EX register, the main
// opcodes, the zero-register index and the main-decoder control table.
// Control bundle, MSB first:
//   {branch, jump, reg_dst, we_reg, alu_src, we_dm, dm2reg, alu_op[1:0],
//    jal_wd_sel, jal_wa_sel}
package mips_pipe_pkg;

    localparam int CTRL_W = 11;

    localparam int CTRL_BRANCH     = 10;
    localparam int CTRL_JUMP       = 9;
    localparam int CTRL_REG_DST    = 8;
    localparam int CTRL_WE_REG     = 7;
    localparam int CTRL_ALU_SRC    = 6;
    localparam int CTRL_WE_DM      = 5;
    localparam int CTRL_DM2REG     = 4;
    localparam int CTRL_ALU_OP_HI  = 3;
    localparam int CTRL_ALU_OP_LO  = 2;
    localparam int CTRL_JAL_WD_SEL = 1;
    localparam int CTRL_JAL_WA_SEL = 0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Main-decoder control table; unknown opcodes decode to all-zero controls.
    function automatic logic [CTRL_W-1:0] ctrl_for_op(input logic [5:0] op);
        logic [CTRL_W-1:0] c;
        c = '0;
        case (op)
            OP_RTYPE: begin
                c[CTRL_REG_DST]   = 1'b1;
                c[CTRL_WE_REG]    = 1'b1;
                c[CTRL_ALU_OP_HI] = 1'b1;
            end
            OP_ADDI: begin
                c[CTRL_WE_REG]  = 1'b1;
                c[CTRL_ALU_SRC] = 1'b1;
            end
            OP_BEQ: begin
                c[CTRL_BRANCH]    = 1'b1;
                c[CTRL_ALU_OP_LO] = 1'b1;
            end
            OP_J: begin
                c[CTRL_JUMP] = 1'b1;
            end
            OP_SW: begin
                c[CTRL_ALU_SRC] = 1'b1;
                c[CTRL_WE_DM]   = 1'b1;
            end
            OP_LW: begin
                c[CTRL_WE_REG]  = 1'b1;
                c[CTRL_ALU_SRC] = 1'b1;
                c[CTRL_DM2REG]  = 1'b1;
            end
            OP_JAL: begin
                c[CTRL_JUMP]       = 1'b1;
                c[CTRL_WE_REG]     = 1'b1;
                c[CTRL_JAL_WD_SEL] = 1'b1;
                c[CTRL_JAL_WA_SEL] = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// rtl/id_ex_pipe_reg_if.sv - decode-side and EX-side bundles of the ID/EX register
//
// master: decode stage / EX consumer view (drives *_d, observes *_e)
// slave : the ID/EX register itself (consumes *_d, drives *_e)
interface id_ex_pipe_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);

    logic              valid_d;
    logic              branch_d, jump_d, reg_dst_d, we_reg_d, alu_src_d;
    logic              we_dm_d, dm2reg_d, jal_wd_sel_d, jal_wa_sel_d;
    logic [1:0]        alu_op_d;
    logic [DATA_W-1:0] rd1_d, rd2_d, sext_imm_d, pc_plus4_d;
    logic [REG_AW-1:0] rs_d, rt_d, rd_d;

    logic              valid_e;
    logic              branch_e, jump_e, reg_dst_e, we_reg_e, alu_src_e;
    logic              we_dm_e, dm2reg_e, jal_wd_sel_e, jal_wa_sel_e;
    logic [1:0]        alu_op_e;
    logic [DATA_W-1:0] rd1_e, rd2_e, sext_imm_e, pc_plus4_e;
    logic [REG_AW-1:0] rs_e, rt_e, rd_e;

    modport master (
        output valid_d, branch_d, jump_d, reg_dst_d, we_reg_d, alu_src_d,
               we_dm_d, dm2reg_d, jal_wd_sel_d, jal_wa_sel_d, alu_op_d,
               rd1_d, rd2_d, sext_imm_d, pc_plus4_d, rs_d, rt_d, rd_d,
        input  valid_e, branch_e, jump_e, reg_dst_e, we_reg_e, alu_src_e,
               we_dm_e, dm2reg_e, jal_wd_sel_e, jal_wa_sel_e, alu_op_e,
               rd1_e, rd2_e, sext_imm_e, pc_plus4_e, rs_e, rt_e, rd_e
    );

    modport slave (
        input  valid_d, branch_d, jump_d, reg_dst_d, we_reg_d, alu_src_d,
               we_dm_d, dm2reg_d, jal_wd_sel_d, jal_wa_sel_d, alu_op_d,
               rd1_d, rd2_d, sext_imm_d, pc_plus4_d, rs_d, rt_d, rd_d,
        output valid_e, branch_e, jump_e, reg_dst_e, we_reg_e, alu_src_e,
               we_dm_e, dm2reg_e, jal_wd_sel_e, jal_wa_sel_e, alu_op_e,
               rd1_e, rd2_e, sext_imm_e, pc_plus4_e, rs_e, rt_e, rd_e
    );

endinterface

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard detector
//
// Ports:
//   valid_e, dm2reg_e, we_reg_e, rt_e : instruction currently in EX
//   valid_d, rs_d, rt_d              : instruction currently in decode
//   lu                               : decode needs the EX load's result
module load_use_detect
    import mips_pipe_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              valid_e,
    input  logic              dm2reg_e,
    input  logic              we_reg_e,
    input  logic [REG_AW-1:0] rt_e,
    input  logic              valid_d,
    input  logic [REG_AW-1:0] rs_d,
    input  logic [REG_AW-1:0] rt_d,
    output logic              lu
);

    logic ex_is_load;
    logic src_match;

    // A load targeting $zero produces nothing a consumer can depend on.
    assign ex_is_load = valid_e & dm2reg_e & we_reg_e & (rt_e != REG_AW'(REG_ZERO));
    assign src_match  = (rt_e == rs_d) | (rt_e == rt_d);
    assign lu         = ex_is_load & valid_d & src_match;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with load-use bubble insertion
//
// Ports:
//   clk, rst    : rising-edge clock, synchronous active-high reset
//   stall_in    : external freeze, EX-side state holds
//   flush_in    : branch/jump taken, a bubble enters EX
//   pif         : slave view of the decode (*_d) and EX (*_e) bundles
//   stall_fd    : load-use stall to PC and IF/ID (combinational)
//   bubble_cnt  : bubbles loaded by flush or load-use; counts only when
//                 IDEX_PERF_CNT_EN is defined, otherwise tied to 0
//
// Edge priority: rst > flush_in > stall_in > load-use > normal load.
module id_ex_pipe_reg
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_in,
    input  logic                flush_in,
    id_ex_pipe_reg_if.slave     pif,
    output logic                stall_fd,
    output logic [31:0]         bubble_cnt
);

    logic [CTRL_W-1:0] ctrl_in;
    logic [CTRL_W-1:0] ctrl_ex_d, ctrl_ex_q;
    logic              valid_ex_d, valid_ex_q;
    logic [DATA_W-1:0] rd1_ex_d, rd1_ex_q;
    logic [DATA_W-1:0] rd2_ex_d, rd2_ex_q;
    logic [DATA_W-1:0] imm_ex_d, imm_ex_q;
    logic [DATA_W-1:0] pc4_ex_d, pc4_ex_q;
    logic [REG_AW-1:0] rs_ex_d, rs_ex_q;
    logic [REG_AW-1:0] rt_ex_d, rt_ex_q;
    logic [REG_AW-1:0] rd_ex_d, rd_ex_q;

    logic lu;
    logic load_bubble;
    logic load_new;

    assign ctrl_in = {pif.branch_d, pif.jump_d, pif.reg_dst_d, pif.we_reg_d,
                      pif.alu_src_d, pif.we_dm_d, pif.dm2reg_d, pif.alu_op_d,
                      pif.jal_wd_sel_d, pif.jal_wa_sel_d};

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_lu (
        .valid_e  (valid_ex_q),
        .dm2reg_e (ctrl_ex_q[CTRL_DM2REG]),
        .we_reg_e (ctrl_ex_q[CTRL_WE_REG]),
        .rt_e     (rt_ex_q),
        .valid_d  (pif.valid_d),
        .rs_d     (pif.rs_d),
        .rt_d     (pif.rt_d),
        .lu       (lu)
    );

    // stall_fd follows lu even under flush; the upstream flush overrides
    // the IF/ID hold.
    assign stall_fd = lu;

    // Flush beats the external stall; load-use only acts when not frozen.
    assign load_bubble = flush_in | (~stall_in & lu);
    assign load_new    = ~flush_in & ~stall_in & ~lu;

    always_comb begin
        ctrl_ex_d  = ctrl_ex_q;
        valid_ex_d = valid_ex_q;
        rd1_ex_d   = rd1_ex_q;
        rd2_ex_d   = rd2_ex_q;
        imm_ex_d   = imm_ex_q;
        pc4_ex_d   = pc4_ex_q;
        rs_ex_d    = rs_ex_q;
        rt_ex_d    = rt_ex_q;
        rd_ex_d    = rd_ex_q;
        if (load_bubble) begin
            ctrl_ex_d  = '0;
            valid_ex_d = 1'b0;
            rd1_ex_d   = '0;
            rd2_ex_d   = '0;
            imm_ex_d   = '0;
            pc4_ex_d   = '0;
            rs_ex_d    = '0;
            rt_ex_d    = '0;
            rd_ex_d    = '0;
        end else if (load_new) begin
            ctrl_ex_d  = ctrl_in;
            valid_ex_d = pif.valid_d;
            rd1_ex_d   = pif.rd1_d;
            rd2_ex_d   = pif.rd2_d;
            imm_ex_d   = pif.sext_imm_d;
            pc4_ex_d   = pif.pc_plus4_d;
            rs_ex_d    = pif.rs_d;
            rt_ex_d    = pif.rt_d;
            rd_ex_d    = pif.rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_ex_q  <= '0;
            valid_ex_q <= 1'b0;
            rd1_ex_q   <= '0;
            rd2_ex_q   <= '0;
            imm_ex_q   <= '0;
            pc4_ex_q   <= '0;
            rs_ex_q    <= '0;
            rt_ex_q    <= '0;
            rd_ex_q    <= '0;
        end else begin
            ctrl_ex_q  <= ctrl_ex_d;
            valid_ex_q <= valid_ex_d;
            rd1_ex_q   <= rd1_ex_d;
            rd2_ex_q   <= rd2_ex_d;
            imm_ex_q   <= imm_ex_d;
            pc4_ex_q   <= pc4_ex_d;
            rs_ex_q    <= rs_ex_d;
            rt_ex_q    <= rt_ex_d;
            rd_ex_q    <= rd_ex_d;
        end
    end

    assign pif.valid_e      = valid_ex_q;
    assign pif.branch_e     = ctrl_ex_q[CTRL_BRANCH];
    assign pif.jump_e       = ctrl_ex_q[CTRL_JUMP];
    assign pif.reg_dst_e    = ctrl_ex_q[CTRL_REG_DST];
    assign pif.we_reg_e     = ctrl_ex_q[CTRL_WE_REG];
    assign pif.alu_src_e    = ctrl_ex_q[CTRL_ALU_SRC];
    assign pif.we_dm_e      = ctrl_ex_q[CTRL_WE_DM];
    assign pif.dm2reg_e     = ctrl_ex_q[CTRL_DM2REG];
    assign pif.alu_op_e     = ctrl_ex_q[CTRL_ALU_OP_HI:CTRL_ALU_OP_LO];
    assign pif.jal_wd_sel_e = ctrl_ex_q[CTRL_JAL_WD_SEL];
    assign pif.jal_wa_sel_e = ctrl_ex_q[CTRL_JAL_WA_SEL];
    assign pif.rd1_e        = rd1_ex_q;
    assign pif.rd2_e        = rd2_ex_q;
    assign pif.sext_imm_e   = imm_ex_q;
    assign pif.pc_plus4_e   = pc4_ex_q;
    assign pif.rs_e         = rs_ex_q;
    assign pif.rt_e         = rt_ex_q;
    assign pif.rd_e         = rd_ex_q;

`ifdef IDEX_PERF_CNT_EN
    logic [31:0] bubble_cnt_d, bubble_cnt_q;

    // Saturating: the counter sticks at all-ones rather than wrapping.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (load_bubble && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`else
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - self-checking bench for id_ex_pipe_reg
module tb_id_ex_pipe_reg;
    import mips_pipe_pkg::*;

    typedef struct packed {
        logic        valid;
        logic [10:0] ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } instr_t;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        instr_t      d;
        logic        exp_sfd;
        instr_t      exp_e;
        int unsigned exp_cnt;
    } vec_t;

    // Control bundles {branch,jump,reg_dst,we_reg,alu_src,we_dm,dm2reg,alu_op,jal_wd,jal_wa}
    localparam logic [10:0] C_ADDI = 11'h0C0;
    localparam logic [10:0] C_LW   = 11'h0D0;
    localparam logic [10:0] C_SW   = 11'h060;
    localparam logic [10:0] C_R    = 11'h188;

    logic        clk;
    logic        rst;
    logic        stall_in;
    logic        flush_in;
    logic        stall_fd;
    logic [31:0] bubble_cnt;

    int n_checks;
    int n_fail;

    vec_t tbl[$];

    id_ex_pipe_reg_if #(.DATA_W(32), .REG_AW(5)) ifc ();

    id_ex_pipe_reg #(.DATA_W(32), .REG_AW(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_in   (stall_in),
        .flush_in   (flush_in),
        .pif        (ifc),
        .stall_fd   (stall_fd),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic instr_t mk(input logic v, input logic [10:0] c,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] i, input logic [31:0] p,
                                  input logic [4:0] s, input logic [4:0] t,
                                  input logic [4:0] d);
        instr_t x;
        x.valid = v; x.ctrl = c; x.rd1 = a; x.rd2 = b; x.imm = i; x.pc4 = p;
        x.rs = s; x.rt = t; x.rd = d;
        return x;
    endfunction

    function automatic int unsigned cnt_exp(input int unsigned c);
`ifdef IDEX_PERF_CNT_EN
        return c;
`else
        return (c == 32'hFFFF_FFFF) ? 0 : 0;
`endif
    endfunction

    task automatic add(input logic r, input logic s, input logic f, input instr_t d,
                       input logic sfd, input instr_t e, input int unsigned cnt);
        vec_t v;
        v.rst = r; v.stall = s; v.flush = f; v.d = d;
        v.exp_sfd = sfd; v.exp_e = e; v.exp_cnt = cnt;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic r, input logic s, input logic f, input instr_t d);
        rst      = r;
        stall_in = s;
        flush_in = f;
        ifc.valid_d      = d.valid;
        ifc.branch_d     = d.ctrl[10];
        ifc.jump_d       = d.ctrl[9];
        ifc.reg_dst_d    = d.ctrl[8];
        ifc.we_reg_d     = d.ctrl[7];
        ifc.alu_src_d    = d.ctrl[6];
        ifc.we_dm_d      = d.ctrl[5];
        ifc.dm2reg_d     = d.ctrl[4];
        ifc.alu_op_d     = d.ctrl[3:2];
        ifc.jal_wd_sel_d = d.ctrl[1];
        ifc.jal_wa_sel_d = d.ctrl[0];
        ifc.rd1_d        = d.rd1;
        ifc.rd2_d        = d.rd2;
        ifc.sext_imm_d   = d.imm;
        ifc.pc_plus4_d   = d.pc4;
        ifc.rs_d         = d.rs;
        ifc.rt_d         = d.rt;
        ifc.rd_d         = d.rd;
    endtask

    function automatic instr_t sample_e();
        instr_t x;
        x.valid = ifc.valid_e;
        x.ctrl  = {ifc.branch_e, ifc.jump_e, ifc.reg_dst_e, ifc.we_reg_e,
                   ifc.alu_src_e, ifc.we_dm_e, ifc.dm2reg_e, ifc.alu_op_e,
                   ifc.jal_wd_sel_e, ifc.jal_wa_sel_e};
        x.rd1 = ifc.rd1_e; x.rd2 = ifc.rd2_e; x.imm = ifc.sext_imm_e;
        x.pc4 = ifc.pc_plus4_e; x.rs = ifc.rs_e; x.rt = ifc.rt_e; x.rd = ifc.rd_e;
        return x;
    endfunction

    task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // Reference: EX-side content is whichever instruction (or nothing)
    // the priority rules say entered on each edge.
    instr_t      ex_m;
    int unsigned cnt_m;

    function automatic logic model_lu(input instr_t ex, input instr_t d);
        logic ex_load;
        ex_load = ex.valid && ex.ctrl[4] && ex.ctrl[7] && (ex.rt != 5'd0);
        return ex_load && d.valid && ((ex.rt == d.rs) || (ex.rt == d.rt));
    endfunction

    initial begin
        instr_t ones, bub;
        instr_t A, L, D, L0, E, N, F, L2, V0, L3, S, L4, G, H, K, L5, J;
        logic [5:0] ops [7];

        n_checks = 0;
        n_fail   = 0;
        ones = '1;
        bub  = '0;

        A  = mk(1, C_ADDI, 32'h10,  32'h0,  32'h5, 32'h104, 5'd3, 5'd8,  5'd0);
        L  = mk(1, C_LW,   32'h200, 32'h0,  32'h4, 32'h108, 5'd4, 5'd9,  5'd0);
        D  = mk(1, C_R,    32'h11,  32'h22, 32'h0, 32'h10C, 5'd9, 5'd10, 5'd11);
        L0 = mk(1, C_LW,   32'h300, 32'h0,  32'h8, 32'h110, 5'd5, 5'd0,  5'd0);
        E  = mk(1, C_R,    32'h1,   32'h2,  32'h0, 32'h114, 5'd0, 5'd0,  5'd12);
        N  = mk(1, C_ADDI, 32'h7,   32'h0,  32'h1, 32'h118, 5'd1, 5'd9,  5'd0);
        F  = mk(1, C_R,    32'h3,   32'h4,  32'h0, 32'h11C, 5'd9, 5'd2,  5'd13);
        L2 = mk(1, C_LW,   32'h400, 32'h0,  32'h0, 32'h120, 5'd2, 5'd9,  5'd0);
        V0 = mk(0, C_R,    32'h5,   32'h6,  32'h0, 32'h124, 5'd9, 5'd9,  5'd14);
        L3 = mk(1, C_LW,   32'h500, 32'h0,  32'h0, 32'h128, 5'd1, 5'd7,  5'd0);
        S  = mk(1, C_SW,   32'h40,  32'h99, 32'hC, 32'h12C, 5'd7, 5'd6,  5'd0);
        L4 = mk(1, C_LW,   32'h600, 32'h0,  32'h0, 32'h130, 5'd1, 5'd5,  5'd0);
        G  = mk(1, C_R,    32'h8,   32'h9,  32'h0, 32'h134, 5'd5, 5'd1,  5'd15);
        H  = mk(1, C_R,    32'hA,   32'hB,  32'h0, 32'h138, 5'd2, 5'd5,  5'd16);
        K  = mk(1, C_R,    32'hC,   32'hD,  32'h0, 32'h13C, 5'd1, 5'd3,  5'd17);
        L5 = mk(1, C_LW,   32'h700, 32'h0,  32'h0, 32'h140, 5'd1, 5'd4,  5'd0);
        J  = mk(1, C_R,    32'hE,   32'hF,  32'h0, 32'h144, 5'd4, 5'd2,  5'd18);

        //   rst stall flush  d   sfd  exp_e  cnt
        add(0, 0, 0, A,  0, A,   0);
        add(0, 0, 0, L,  0, L,   0);
        add(0, 0, 0, D,  1, bub, 1);   // load-use bubble
        add(0, 0, 0, D,  0, D,   1);   // dependent enters one cycle later
        add(0, 0, 0, L0, 0, L0,  1);
        add(0, 0, 0, E,  0, E,   1);   // load into $zero never stalls
        add(0, 0, 0, N,  0, N,   1);
        add(0, 0, 0, F,  0, F,   1);   // non-load producer never stalls
        add(0, 0, 0, L2, 0, L2,  1);
        add(0, 0, 0, V0, 0, V0,  1);   // invalid decode never stalls
        add(0, 0, 0, L3, 0, L3,  1);
        add(0, 1, 1, S,  1, bub, 2);   // flush beats stall and lu
        add(0, 0, 0, L4, 0, L4,  2);
        add(0, 1, 0, G,  1, L4,  2);   // stall holds, lu stays visible
        add(0, 1, 0, H,  1, L4,  2);
        add(0, 1, 0, K,  0, L4,  2);
        add(0, 0, 0, G,  1, bub, 3);
        add(0, 0, 0, G,  0, G,   3);
        add(0, 0, 0, L5, 0, L5,  3);
        add(1, 0, 0, J,  1, bub, 0);   // reset mid-hazard
        add(0, 0, 0, J,  0, J,   0);
        add(0, 0, 1, A,  0, bub, 1);   // plain flush

        // Reset with decode inputs all ones for two cycles
        drive(1, 0, 0, ones);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset_e", 160'(sample_e()), 160'(bub));
        check("reset_stall_fd", 160'(stall_fd), 160'(1'b0));
        check("reset_cnt", 160'(bubble_cnt), 160'(cnt_exp(0)));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].stall, tbl[i].flush, tbl[i].d);
            #1;
            check($sformatf("vec%0d_stall_fd", i), 160'(stall_fd), 160'(tbl[i].exp_sfd));
            @(posedge clk); #1;
            check($sformatf("vec%0d_e", i), 160'(sample_e()), 160'(tbl[i].exp_e));
            check($sformatf("vec%0d_cnt", i), 160'(bubble_cnt), 160'(cnt_exp(tbl[i].exp_cnt)));
        end

        // Randomised traffic against the reference model
        ops[0] = OP_RTYPE; ops[1] = OP_ADDI; ops[2] = OP_BEQ; ops[3] = OP_J;
        ops[4] = OP_SW;    ops[5] = OP_LW;   ops[6] = OP_JAL;
        drive(1, 0, 0, bub);
        @(posedge clk); #1;
        ex_m  = '0;
        cnt_m = 0;
        for (int n = 0; n < 3000; n++) begin
            instr_t d;
            logic r, s, f, lu_m;
            r = ($urandom_range(0, 99) == 0);
            s = ($urandom_range(0, 7) == 0);
            f = ($urandom_range(0, 7) == 0);
            d.valid = ($urandom_range(0, 7) != 0);
            d.ctrl  = ($urandom_range(0, 9) == 0) ? 11'($urandom)
                                                  : ctrl_for_op(ops[$urandom_range(0, 6)]);
            d.rd1 = $urandom; d.rd2 = $urandom; d.imm = $urandom; d.pc4 = $urandom;
            d.rs  = 5'($urandom_range(0, 3));
            d.rt  = 5'($urandom_range(0, 3));
            d.rd  = 5'($urandom_range(0, 3));
            lu_m = model_lu(ex_m, d);
            drive(r, s, f, d);
            #1;
            check("rand_stall_fd", 160'(stall_fd), 160'(lu_m));
            @(posedge clk); #1;
            if (r) begin
                ex_m = '0; cnt_m = 0;
            end else if (f || (!s && lu_m)) begin
                ex_m = '0;
                if (cnt_m != 32'hFFFF_FFFF) cnt_m++;
            end else if (!s) begin
                ex_m = d;
            end
            check("rand_e", 160'(sample_e()), 160'(ex_m));
            check("rand_cnt", 160'(bubble_cnt), 160'(cnt_exp(cnt_m)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
